// File: rtl/gsensor_spi_responder.sv
// gsensor_spi_responder: ADXL345-style SPI responder (mode 3, MSB first, 3-wire SDIO)
// with a 64x8 register file, X/Y/Z sample capture and a DATA_READY interrupt.
// Optional build macro SPI_FOUR_WIRE_EN: adds the spi_sdo port; DATA_FORMAT[6] then
// selects 4-wire (0, read data on spi_sdo) or 3-wire (1, read data on SDIO).
module gsensor_spi_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  DEVID_VALUE = 8'hE5
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_sdio_in,
    output logic        spi_sdio_out,
    output logic        spi_sdio_oe,
    output logic        spi_int,
`ifdef SPI_FOUR_WIRE_EN
    output logic        spi_sdo,
`endif
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    input  logic        sample_valid,
    output logic        reg_wr_strobe,
    output logic [5:0]  reg_wr_addr,
    output logic [7:0]  reg_wr_data
);

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned NREGS  = 64;
    localparam int unsigned CNT_W  = 3;

    localparam logic [ADDR_W-1:0] A_DEVID       = 6'h00;
    localparam logic [ADDR_W-1:0] A_INT_ENABLE  = 6'h2E;
    localparam logic [ADDR_W-1:0] A_INT_SOURCE  = 6'h30;
`ifdef SPI_FOUR_WIRE_EN
    localparam logic [ADDR_W-1:0] A_DATA_FORMAT = 6'h31;
`endif
    localparam logic [ADDR_W-1:0] A_DATAX0      = 6'h32;
    localparam logic [ADDR_W-1:0] A_DATAX1      = 6'h33;
    localparam logic [ADDR_W-1:0] A_DATAY0      = 6'h34;
    localparam logic [ADDR_W-1:0] A_DATAY1      = 6'h35;
    localparam logic [ADDR_W-1:0] A_DATAZ0      = 6'h36;
    localparam logic [ADDR_W-1:0] A_DATAZ1      = 6'h37;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sdio_sync;
    logic                   sclk_s, cs_s, sdio_s;
    logic                   sclk_prev, cs_prev;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [DATA_W-1:0]      regs [NREGS];
    logic [DATA_W-1:0]      int_src_nxt;

    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_W-2:0]      shreg;
    logic [DATA_W-1:0]      rx_byte;
    logic [DATA_W-1:0]      tx_byte;
    logic [ADDR_W-1:0]      addr;
    logic [ADDR_W-1:0]      addr_adv;
    logic                   mb;
    logic                   byte_done;
    logic                   wr_protected;
    logic                   wr_fire;
    logic                   rd_done;
    logic                   three_wire;

    logic [15:0]            sbuf_x, sbuf_y, sbuf_z;
    logic                   pend;
    logic                   imm_commit;
    logic                   commit;

    // Pin synchronisers plus one-cycle history for edge detection.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sclk_sync <= '1;
            cs_sync   <= '1;
            sdio_sync <= '0;
            sclk_prev <= 1'b1;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sdio_sync <= {sdio_sync[SYNC_STAGES-2:0], spi_sdio_in};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sdio_s    = sdio_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_rise   = cs_s & ~cs_prev;
    assign cs_fall   = ~cs_s & cs_prev;

`ifdef SPI_FOUR_WIRE_EN
    assign three_wire = regs[A_DATA_FORMAT][6];
`else
    assign three_wire = 1'b1;
`endif

    // Byte-level decode shared by the FSM, shifter and register file.
    always_comb begin
        rx_byte      = {shreg, sdio_s};
        byte_done    = sclk_rise && (bit_cnt == 3'd7) && (state != IDLE) && !cs_s;
        addr_adv     = mb ? (addr + 6'd1) : addr;
        wr_protected = (addr == A_DEVID) || (addr == A_INT_SOURCE) ||
                       ((addr >= A_DATAX0) && (addr <= A_DATAZ1));
        wr_fire      = byte_done && (state == WDATA) && !wr_protected;
        rd_done      = byte_done && (state == RDATA);
        commit       = imm_commit || (pend && cs_rise);
    end

    // FSM state register.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: CS_N high always returns to IDLE.
    always_comb begin
        state_nxt = state;
        if (cs_s) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (cs_fall) state_nxt = CMD;
                CMD:     if (byte_done) state_nxt = rx_byte[7] ? RDATA : WDATA;
                default: state_nxt = state;
            endcase
        end
    end

    // Shift register, address tracking and read-data drive on SCLK falls.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            bit_cnt      <= '0;
            shreg        <= '0;
            mb           <= 1'b0;
            addr         <= '0;
            tx_byte      <= '0;
            spi_sdio_out <= 1'b0;
            spi_sdio_oe  <= 1'b0;
`ifdef SPI_FOUR_WIRE_EN
            spi_sdo      <= 1'b0;
`endif
        end else if (cs_s || (state == IDLE)) begin
            bit_cnt      <= '0;
            spi_sdio_out <= 1'b0;
            spi_sdio_oe  <= 1'b0;
`ifdef SPI_FOUR_WIRE_EN
            spi_sdo      <= 1'b0;
`endif
        end else begin
            if (sclk_rise) begin
                shreg   <= rx_byte[DATA_W-2:0];
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (byte_done) begin
                case (state)
                    CMD: begin
                        mb      <= rx_byte[6];
                        addr    <= rx_byte[5:0];
                        tx_byte <= regs[rx_byte[5:0]];
                    end
                    WDATA: addr <= addr_adv;
                    RDATA: begin
                        addr    <= addr_adv;
                        tx_byte <= regs[addr_adv];
                    end
                    default: ;
                endcase
            end
            if (sclk_fall && (state == RDATA)) begin
                tx_byte <= {tx_byte[DATA_W-2:0], 1'b0};
                if (three_wire) begin
                    spi_sdio_out <= tx_byte[7];
                    spi_sdio_oe  <= 1'b1;
`ifdef SPI_FOUR_WIRE_EN
                    spi_sdo      <= 1'b0;
                end else begin
                    spi_sdo      <= tx_byte[7];
`endif
                end
            end
        end
    end

    // Sample capture: immediate commit when idle, one-deep pending buffer mid-transaction.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sbuf_x     <= '0;
            sbuf_y     <= '0;
            sbuf_z     <= '0;
            pend       <= 1'b0;
            imm_commit <= 1'b0;
        end else begin
            imm_commit <= sample_valid && cs_s;
            if (pend && cs_rise) begin
                pend <= 1'b0;
            end
            if (sample_valid) begin
                sbuf_x <= sample_x;
                sbuf_y <= sample_y;
                sbuf_z <= sample_z;
                if (!cs_s) begin
                    pend <= 1'b1;
                end
            end
        end
    end

    // INT_SOURCE update: read of DATAZ1 clears, commits and overruns set (set wins).
    always_comb begin
        int_src_nxt = regs[A_INT_SOURCE];
        if (rd_done && (addr == A_DATAZ1)) begin
            int_src_nxt[7] = 1'b0;
            int_src_nxt[0] = 1'b0;
        end
        if (commit) begin
            if (regs[A_INT_SOURCE][7]) begin
                int_src_nxt[0] = 1'b1;
            end
            int_src_nxt[7] = 1'b1;
        end
        if (sample_valid && !cs_s && pend) begin
            int_src_nxt[0] = 1'b1;
        end
    end

    // Register file: SPI writes, sample commits and interrupt source.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[6'(i)] <= (i == 0) ? DEVID_VALUE : 8'h00;
            end
        end else begin
            if (wr_fire) begin
                regs[addr] <= rx_byte;
            end
            if (commit) begin
                regs[A_DATAX0] <= sbuf_x[7:0];
                regs[A_DATAX1] <= sbuf_x[15:8];
                regs[A_DATAY0] <= sbuf_y[7:0];
                regs[A_DATAY1] <= sbuf_y[15:8];
                regs[A_DATAZ0] <= sbuf_z[7:0];
                regs[A_DATAZ1] <= sbuf_z[15:8];
            end
            regs[A_INT_SOURCE] <= int_src_nxt;
        end
    end

    // Write notification towards the system side.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            reg_wr_strobe <= 1'b0;
            reg_wr_addr   <= '0;
            reg_wr_data   <= '0;
        end else begin
            reg_wr_strobe <= wr_fire;
            if (wr_fire) begin
                reg_wr_addr <= addr;
                reg_wr_data <= rx_byte;
            end
        end
    end

    // Interrupt pin: DATA_READY gated by its enable.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            spi_int <= 1'b0;
        end else begin
            spi_int <= regs[A_INT_SOURCE][7] & regs[A_INT_ENABLE][7];
        end
    end

endmodule

// File: tb/tb_gsensor_spi_responder.sv
// Self-checking bench for gsensor_spi_responder: directed scenarios plus a random
// mix of transactions and samples, checked against a transaction-level register model.
module tb_gsensor_spi_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk, cs_n, sdio_in;
    logic        sdio_out, sdio_oe, int_o;
    logic [15:0] sx, sy, sz;
    logic        sample_valid;
    logic        wr_strobe;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;
`ifdef SPI_FOUR_WIRE_EN
    logic        sdo;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [7:0]  m_mem [64];
    logic        m_pend;
    logic        m_in_txn;
    logic [15:0] m_px, m_py, m_pz;
    logic [13:0] exp_wr [$];
    logic [13:0] got_wr [$];

    gsensor_spi_responder dut (
        .clk_clk       (clk),
        .reset_reset   (rst),
        .spi_sclk      (sclk),
        .spi_cs_n      (cs_n),
        .spi_sdio_in   (sdio_in),
        .spi_sdio_out  (sdio_out),
        .spi_sdio_oe   (sdio_oe),
        .spi_int       (int_o),
`ifdef SPI_FOUR_WIRE_EN
        .spi_sdo       (sdo),
`endif
        .sample_x      (sx),
        .sample_y      (sy),
        .sample_z      (sz),
        .sample_valid  (sample_valid),
        .reg_wr_strobe (wr_strobe),
        .reg_wr_addr   (wr_addr),
        .reg_wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    // Record every write strobe seen by the system side.
    always @(negedge clk) begin
        if (!rst && wr_strobe) got_wr.push_back({wr_addr, wr_data});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- model ----------------
    function automatic void m_reset();
        for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
        m_mem[0] = 8'hE5;
        m_pend = 1'b0;
        m_in_txn = 1'b0;
    endfunction

    function automatic void m_commit(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        if (m_mem[6'h30][7]) m_mem[6'h30][0] = 1'b1;
        m_mem[6'h30][7] = 1'b1;
        m_mem[6'h32] = x[7:0];  m_mem[6'h33] = x[15:8];
        m_mem[6'h34] = y[7:0];  m_mem[6'h35] = y[15:8];
        m_mem[6'h36] = z[7:0];  m_mem[6'h37] = z[15:8];
    endfunction

    function automatic void m_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        if (m_in_txn) begin
            if (m_pend) m_mem[6'h30][0] = 1'b1;
            m_pend = 1'b1;
            m_px = x; m_py = y; m_pz = z;
        end else begin
            m_commit(x, y, z);
        end
    endfunction

    function automatic void m_write(input logic [5:0] a, input logic [7:0] d);
        if (!(a == 6'h00 || a == 6'h30 || (a >= 6'h32 && a <= 6'h37))) begin
            m_mem[a] = d;
            exp_wr.push_back({a, d});
        end
    endfunction

    function automatic logic m_int();
        return m_mem[6'h30][7] & m_mem[6'h2E][7];
    endfunction

    function automatic logic m_three_wire();
`ifdef SPI_FOUR_WIRE_EN
        return m_mem[6'h31][6];
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic rd_pin();
`ifdef SPI_FOUR_WIRE_EN
        return m_three_wire() ? sdio_out : sdo;
`else
        return sdio_out;
`endif
    endfunction

    // ---------------- master side ----------------
    task automatic cs_low();
        cs_n = 1'b0;
        tick(6);
        m_in_txn = 1'b1;
    endtask

    task automatic cs_high();
        cs_n = 1'b1;
        tick(6);
        m_in_txn = 1'b0;
        if (m_pend) begin
            m_commit(m_px, m_py, m_pz);
            m_pend = 1'b0;
        end
    endtask

    // Mode 3: drive on SCLK fall, sample slave data at SCLK rise.
    task automatic spi_bits(input logic [7:0] dout, input int nbits, output logic [7:0] din,
                            output logic oe_any, output logic oe_all);
        din = 8'h00; oe_any = 1'b0; oe_all = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0; sdio_in = dout[7-i];
            tick(5);
            sclk = 1'b1;
            din[7-i] = rd_pin();
            oe_any = oe_any | sdio_oe;
            oe_all = oe_all & sdio_oe;
            tick(5);
        end
    endtask

    task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        sx = x; sy = y; sz = z;
        sample_valid = 1'b1;
        tick(1);
        sample_valid = 1'b0;
        tick(3);
        m_sample(x, y, z);
    endtask

    task automatic check_strobes();
        check("wr_count", 32'(got_wr.size()), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            check("wr_event", 32'(got_wr[i]), 32'(exp_wr[i]));
        got_wr.delete();
        exp_wr.delete();
    endtask

    // inj bit k: pulse a random sample after byte k (bit 0 = after the command byte).
    task automatic read_txn(input logic [5:0] addr, input logic mb, input int nbytes, input logic [7:0] inj);
        logic [7:0] din, exp;
        logic       oe_any, oe_all;
        logic [5:0] a;
        a = addr;
        cs_low();
        spi_bits({1'b1, mb, addr}, 8, din, oe_any, oe_all);
        check("cmd_oe", 32'(oe_any), 32'h0);
        exp = m_mem[a];
        if (inj[0]) pulse_sample(16'($urandom), 16'($urandom), 16'($urandom));
        for (int k = 0; k < nbytes; k++) begin
            spi_bits(8'h00, 8, din, oe_any, oe_all);
            check("rd_data", 32'(din), 32'(exp));
            check("rd_oe", 32'({oe_any, oe_all}), 32'({m_three_wire(), m_three_wire()}));
            if (a == 6'h37) begin
                m_mem[6'h30][7] = 1'b0;
                m_mem[6'h30][0] = 1'b0;
            end
            if (mb) a = a + 6'd1;
            exp = m_mem[a];
            if (k < 7 && inj[k+1]) pulse_sample(16'($urandom), 16'($urandom), 16'($urandom));
        end
        cs_high();
        check("rd_oe_idle", 32'(sdio_oe), 32'h0);
        check("int", 32'(int_o), 32'(m_int()));
    endtask

    task automatic write_txn(input logic [5:0] addr, input logic mb, input int nbytes, input logic [63:0] data);
        logic [7:0] din, b;
        logic       oe_any, oe_all;
        logic [5:0] a;
        a = addr;
        cs_low();
        spi_bits({1'b0, mb, addr}, 8, din, oe_any, oe_all);
        for (int k = 0; k < nbytes; k++) begin
            b = data[8*k +: 8];
            spi_bits(b, 8, din, oe_any, oe_all);
            check("wr_oe", 32'(oe_any), 32'h0);
            m_write(a, b);
            if (mb) a = a + 6'd1;
        end
        cs_high();
        check_strobes();
        check("int", 32'(int_o), 32'(m_int()));
    endtask

    initial begin
        logic [7:0] din;
        logic       oe_any, oe_all;
        rst = 1'b1; sclk = 1'b1; cs_n = 1'b1; sdio_in = 1'b0;
        sample_valid = 1'b0; sx = '0; sy = '0; sz = '0;
        m_reset();
        tick(5);
        check("rst_sdio_out", 32'(sdio_out), 32'h0);
        check("rst_oe", 32'(sdio_oe), 32'h0);
        check("rst_int", 32'(int_o), 32'h0);
        check("rst_strobe", 32'(wr_strobe), 32'h0);
        check("rst_wr_addr", 32'(wr_addr), 32'h0);
        check("rst_wr_data", 32'(wr_data), 32'h0);
        rst = 1'b0;
        tick(5);

        // DEVID read right after reset.
        read_txn(6'h00, 1'b0, 1, 8'h00);

        // Interrupt enable, idle sample, burst read of the data registers.
        write_txn(6'h2E, 1'b0, 1, 64'h80);
        pulse_sample(16'h0123, 16'hFF80, 16'h0004);
        check("int_after_sample", 32'(int_o), 32'h1);
        read_txn(6'h32, 1'b1, 6, 8'h00);
        check("int_after_z1", 32'(int_o), 32'h0);

        // Samples during a burst are deferred; second one flags overrun.
        read_txn(6'h32, 1'b1, 6, 8'b0100_0010);
        read_txn(6'h30, 1'b0, 1, 8'h00);
        check("int_source_0x81", 32'(m_mem[6'h30]), 32'h81);
        read_txn(6'h32, 1'b1, 6, 8'h00);

        // MB write wrapping from 0x3F into protected 0x00.
        write_txn(6'h3F, 1'b1, 2, 64'h55AA);
        read_txn(6'h00, 1'b0, 1, 8'h00);

        // Aborted write: partial byte discarded.
        cs_low();
        spi_bits(8'h2D, 8, din, oe_any, oe_all);
        spi_bits(8'hF0, 4, din, oe_any, oe_all);
        cs_high();
        check("abort_oe", 32'(sdio_oe), 32'h0);
        check_strobes();
        read_txn(6'h2D, 1'b0, 1, 8'h00);

        // DATA_FORMAT 3/4-wire select.
        write_txn(6'h31, 1'b0, 1, 64'h00);
        read_txn(6'h00, 1'b0, 1, 8'h00);
        write_txn(6'h31, 1'b0, 1, 64'h40);
        read_txn(6'h00, 1'b0, 1, 8'h00);

        // Random mix.
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: write_txn(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                             int'($urandom_range(1, 3)), {$urandom, $urandom});
                1: read_txn(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                            int'($urandom_range(1, 4)), 8'($urandom) & 8'h1F);
                2: begin
                    pulse_sample(16'($urandom), 16'($urandom), 16'($urandom));
                    check("int_idle_sample", 32'(int_o), 32'(m_int()));
                end
                default: read_txn(6'h32, 1'b1, 6, 8'($urandom) & 8'h7F);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
